// File: rtl/epm3032_ym_bus_sequencer.sv
// Two-requester write sequencer for a pair of AY/YM PSGs: round-robin arbitration,
// then a fixed ADDR/GAP1/DATA/GAP2 bus cycle with HOLD_CYCLES clocks per phase.
module epm3032_ym_bus_sequencer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       cpu_valid,
    output logic       cpu_ready,
    input  logic       cpu_chip,
    input  logic [3:0] cpu_reg,
    input  logic [7:0] cpu_data,
    input  logic       ply_valid,
    output logic       ply_ready,
    input  logic       ply_chip,
    input  logic [3:0] ply_reg,
    input  logic [7:0] ply_data,
    output logic       bdir,
    output logic       bc1,
    output logic [1:0] ym_sel_n,
    output logic [7:0] da_out,
    output logic       da_oe,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_e;

    localparam logic [3:0] LOAD = 4'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       chip_q, chip_d;
    logic [3:0] reg_q, reg_d;
    logic [7:0] data_q, data_d;
    logic       prefer_ply_q, prefer_ply_d;
    logic       grant_ply;
    logic       phase_done;

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            chip_q       <= 1'b0;
            reg_q        <= 4'd0;
            data_q       <= 8'd0;
            prefer_ply_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chip_q       <= chip_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            prefer_ply_q <= prefer_ply_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chip_d       = chip_q;
        reg_d        = reg_q;
        data_d       = data_q;
        prefer_ply_d = prefer_ply_q;
        grant_ply    = 1'b0;
        cpu_ready    = 1'b0;
        ply_ready    = 1'b0;
        bdir         = 1'b0;
        bc1          = 1'b0;
        da_out       = 8'd0;
        da_oe        = 1'b0;
        ym_sel_n     = 2'b11;
        busy         = 1'b1;
        phase_done   = (cnt_q == 4'd0);

        if (state_q != IDLE) begin
            ym_sel_n = chip_q ? 2'b01 : 2'b10;
            cnt_d    = phase_done ? LOAD : cnt_q - 4'd1;
        end

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                // Ready is gated by reset so a request held through reset is not consumed.
                if (!reset && (cpu_valid || ply_valid)) begin
                    grant_ply    = ply_valid && (!cpu_valid || prefer_ply_q);
                    cpu_ready    = !grant_ply;
                    ply_ready    = grant_ply;
                    chip_d       = grant_ply ? ply_chip : cpu_chip;
                    reg_d        = grant_ply ? ply_reg  : cpu_reg;
                    data_d       = grant_ply ? ply_data : cpu_data;
                    prefer_ply_d = !grant_ply;
                    cnt_d        = LOAD;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                bdir   = 1'b1;
                bc1    = 1'b1;
                da_out = {4'b0000, reg_q};
                da_oe  = 1'b1;
                if (phase_done) state_d = GAP1;
            end
            GAP1: begin
                da_out = {4'b0000, reg_q};
                da_oe  = 1'b1;
                if (phase_done) state_d = DATA;
            end
            DATA: begin
                bdir   = 1'b1;
                da_out = data_q;
                da_oe  = 1'b1;
                if (phase_done) state_d = GAP2;
            end
            GAP2: begin
                da_out = data_q;
                if (phase_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/epm3032_ym_bus_sequencer.md
EPM3032_YM_BUS_SEQUENCER -- requirements
Module: ym_bus_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: clocks per bus phase; legal range 1..15.
REQ-002 Port cpu_clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port cpu_valid  in  1  CPU-side request, level, held until accepted.
REQ-005 Port cpu_ready  out  1  one-cycle accept pulse for the CPU request.
REQ-006 Port cpu_chip, cpu_reg, cpu_data  in  1/4/8  target chip (0/1), PSG register, value.
REQ-007 Port ply_valid, ply_ready, ply_chip, ply_reg, ply_data  in/out/in/in/in  1/1/1/4/8  player-side request, same semantics as the CPU side.
REQ-008 Port bdir  out  1  PSG BDIR.
REQ-009 Port bc1  out  1  PSG BC1.
REQ-010 Port ym_sel_n  out  2  active-low chip selects; bit n selects chip n.
REQ-011 Port da_out  out  8  PSG data/address bus value.
REQ-012 Port da_oe  out  1  drive enable for da_out.
REQ-013 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, ADDR, GAP1, DATA, GAP2; a phase counter of 4 bits shall time each non-IDLE state.
REQ-015 In IDLE with at least one valid, the arbiter grants one requester, asserts its ready for exactly that cycle, latches chip/reg/data, and enters ADDR next cycle.
REQ-016 Arbitration is round-robin: when both are valid, the requester not granted last wins; after reset the CPU side wins the first tie.
REQ-017 A single valid requester is granted regardless of round-robin history.
REQ-018 No grant and no ready pulse occur outside IDLE; requests arriving while busy wait.
REQ-019 ADDR: bdir=1, bc1=1, da_out={4'b0000, reg}, da_oe=1, for HOLD_CYCLES clocks.
REQ-020 GAP1: bdir=0, bc1=0, da_oe=1, da_out unchanged, for HOLD_CYCLES clocks.
REQ-021 DATA: bdir=1, bc1=0, da_out=data, da_oe=1, for HOLD_CYCLES clocks.
REQ-022 GAP2: bdir=0, bc1=0, da_oe=0, for HOLD_CYCLES clocks, then IDLE.
REQ-023 A transaction therefore occupies 4*HOLD_CYCLES clocks after the grant cycle; back-to-back grant possible in the first IDLE cycle after GAP2.
REQ-024 ym_sel_n: the latched chip's bit is driven low from the first ADDR cycle through the last GAP2 cycle; both bits high in IDLE.
REQ-025 bdir and bc1 change only on state transitions; never bdir=0 with bc1=1 (read) in any state.
REQ-026 Phase counter loads HOLD_CYCLES-1 on state entry and decrements; transition occurs when it reads 0 (no wrap).
REQ-027 Request fields changing while not ready shall not affect a latched transaction.

Reset
REQ-028 On reset high at a clock edge: state IDLE, bdir=0, bc1=0, ym_sel_n=2'b11, da_out=0, da_oe=0, busy=0, cpu_ready=0, ply_ready=0, round-robin favours CPU.
REQ-029 Reset mid-transaction aborts it immediately; the aborted request is not re-issued.
REQ-030 Requests valid during reset are not granted until the first edge with reset low.

Verification
REQ-031 HOLD_CYCLES=4, CPU writes chip0 reg 7 value 0x38 -> cpu_ready 1 cycle; ADDR 4 clk da_out=0x07 bdir=bc1=1; GAP1 4; DATA 4 da_out=0x38; GAP2 4; ym_sel_n=2'b10 for 16 clk.
REQ-032 Both valid from reset, each holding two requests -> grant order CPU, PLY, CPU, PLY; each ready pulse 17 clocks apart.
REQ-033 Only player valid with chip1 reg 0x0D data 0x0E -> ply_ready, ym_sel_n=2'b01, da_out 0x0D then 0x0E.
REQ-034 Reset asserted in third DATA clock -> next cycle bdir=0, bc1=0, ym_sel_n=2'b11, da_oe=0, busy=0; no resumption.
REQ-035 HOLD_CYCLES=1 -> transaction of 4 clocks, grant-to-grant 5 clocks under continuous requests.
REQ-036 Change cpu_data during DATA of a granted CPU write -> da_out holds latched value through DATA.
